// File: rtl/test_fifo_pkg.sv
// rtl/test_fifo_pkg.sv - shared parameters and segment record layout for test_fifo
//
// Purpose: default widths/depth for the width-converting segment FIFO and the
// bit positions of the on/off/repeat fields inside one 128-bit segment record.
// Ports: none (package).

package test_fifo_pkg;

    localparam int DEF_WR_WIDTH = 16;
    localparam int DEF_RD_WIDTH = 128;
    localparam int DEF_RD_DEPTH = 512;
    localparam int DEF_RATIO    = DEF_RD_WIDTH / DEF_WR_WIDTH;

    localparam int ON_MSB  = 127;
    localparam int ON_LSB  = 80;
    localparam int OFF_MSB = 79;
    localparam int OFF_LSB = 32;
    localparam int REP_MSB = 31;
    localparam int REP_LSB = 0;

    // Assemble a segment record from its three fields.
    function automatic logic [DEF_RD_WIDTH-1:0] seg_pack(
        input logic [ON_MSB-ON_LSB:0]   on_counts,
        input logic [OFF_MSB-OFF_LSB:0] off_counts,
        input logic [REP_MSB-REP_LSB:0] repeat_counts
    );
        logic [DEF_RD_WIDTH-1:0] v;
        v                   = '0;
        v[ON_MSB:ON_LSB]    = on_counts;
        v[OFF_MSB:OFF_LSB]  = off_counts;
        v[REP_MSB:REP_LSB]  = repeat_counts;
        return v;
    endfunction

endpackage

// File: rtl/fifo_sdp_ram.sv
// rtl/fifo_sdp_ram.sv - simple dual-port record RAM with registered read port
//
// Purpose: WIDTH x DEPTH storage, synchronous write, synchronous read into an
// output register that holds its value when no read is issued.
// Ports:
//   clk      in   clock
//   rst      in   async active-high reset, clears the read register only
//   i_we     in   write enable
//   i_waddr  in   write address
//   i_wdata  in   write data
//   i_re     in   read enable
//   i_raddr  in   read address
//   o_rdata  out  registered read data

import test_fifo_pkg::*;

module fifo_sdp_ram #(
    parameter int WIDTH = DEF_RD_WIDTH,
    parameter int DEPTH = DEF_RD_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_re,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // Array has no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/test_fifo.sv
// rtl/test_fifo.sv - 16-bit to 128-bit packing FIFO for clock-segment records
//
// Purpose: packs RATIO consecutive write words (first word in the MS slice)
// into one record, stores up to RD_DEPTH records, and pops whole records.
// Ports:
//   clk        in   single clock
//   rst        in   async active-high reset
//   din        in   write word
//   wr_en      in   write strobe
//   rd_en      in   read strobe (pops one record)
//   dout       out  registered read record, valid the cycle after rd_en
//   empty      out  no complete record stored
//   full       out  RD_DEPTH records stored
//   overflow   out  pulse: previous-cycle write rejected
//   underflow  out  pulse: previous-cycle read rejected

import test_fifo_pkg::*;

module test_fifo #(
    parameter int WR_WIDTH = DEF_WR_WIDTH,
    parameter int RD_WIDTH = DEF_RD_WIDTH,
    parameter int RD_DEPTH = DEF_RD_DEPTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WR_WIDTH-1:0] din,
    input  logic                wr_en,
    input  logic                rd_en,
    output logic [RD_WIDTH-1:0] dout,
    output logic                empty,
    output logic                full,
    output logic                overflow,
    output logic                underflow
);

    localparam int RATIO = RD_WIDTH / WR_WIDTH;
    localparam int AW    = $clog2(RD_DEPTH);
    localparam int CW    = AW + 1;
    // Keep the index at least one bit wide so RATIO=1 still elaborates.
    localparam int IDXW  = (RATIO > 1) ? $clog2(RATIO) : 1;

    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(RATIO - 1);
    localparam logic [CW-1:0]   CNT_FULL = CW'(RD_DEPTH);

    logic [AW-1:0]       r_wptr;
    logic [AW-1:0]       r_rptr;
    logic [CW-1:0]       r_count;
    logic [IDXW-1:0]     r_idx;
    logic [RD_WIDTH-1:0] r_pack;
    logic                r_empty;
    logic                r_full;
    logic                r_overflow;
    logic                r_underflow;

    logic                w_wr_ok;
    logic                w_commit;
    logic                w_pop;
    logic [RD_WIDTH-1:0] w_rec;
    logic [CW-1:0]       w_count_nxt;

    // Flags are the registered status, so a same-cycle pop never frees a slot
    // for a write and a same-cycle commit never supplies a pop.
    assign w_wr_ok  = wr_en & ~r_full;
    assign w_commit = w_wr_ok & (r_idx == IDX_LAST);
    assign w_pop    = rd_en & ~r_empty;

    // Packing register with the current word merged in; this is what gets
    // committed on the last word so the RAM sees the complete record.
    always_comb begin
        w_rec = r_pack;
        w_rec[(RATIO - 1 - int'(r_idx)) * WR_WIDTH +: WR_WIDTH] = din;
    end

    always_comb begin
        w_count_nxt = r_count;
        if (w_commit && !w_pop) begin
            w_count_nxt = r_count + CW'(1);
        end else if (w_pop && !w_commit) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_idx       <= '0;
            r_pack      <= '0;
            r_empty     <= 1'b1;
            r_full      <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_pack <= w_rec;
                r_idx  <= (r_idx == IDX_LAST) ? '0 : r_idx + IDXW'(1);
            end
            if (w_commit) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_count     <= w_count_nxt;
            r_empty     <= (w_count_nxt == '0);
            r_full      <= (w_count_nxt == CNT_FULL);
            r_overflow  <= wr_en & r_full;
            r_underflow <= rd_en & r_empty;
        end
    end

    fifo_sdp_ram #(
        .WIDTH (RD_WIDTH),
        .DEPTH (RD_DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_commit),
        .i_waddr (r_wptr),
        .i_wdata (w_rec),
        .i_re    (w_pop),
        .i_raddr (r_rptr),
        .o_rdata (dout)
    );

    assign empty     = r_empty;
    assign full      = r_full;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule

// File: tb/tb_test_fifo.sv
// tb/tb_test_fifo.sv - directed self-checking bench for test_fifo

import test_fifo_pkg::*;

module tb_test_fifo;

    logic         clk;
    logic         rst;
    logic [15:0]  din;
    logic         wr_en;
    logic         rd_en;
    logic [127:0] dout;
    logic         empty;
    logic         full;
    logic         overflow;
    logic         underflow;

    int total;
    int bad;

    test_fifo dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .dout      (dout),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rec_of(input logic [15:0] base);
        logic [127:0] r;
        r = '0;
        for (int j = 0; j < DEF_RATIO; j++) begin
            r[127 - 16*j -: 16] = base + 16'(j);
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [15:0] w);
        din   = w;
        wr_en = 1'b1;
        step();
        wr_en = 1'b0;
    endtask

    task automatic read_rec();
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    logic [15:0]  base;
    logic [127:0] seg;

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        din   = '0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        step();
        step();
        check_eq("rst_dout", dout, 128'h0);
        check_eq("rst_empty", 128'(empty), 128'(1));
        check_eq("rst_full", 128'(full), 128'(0));
        check_eq("rst_ovf", 128'(overflow), 128'(0));
        check_eq("rst_udf", 128'(underflow), 128'(0));
        rst = 1'b0;

        // Basic packing: first word lands in the top slice.
        for (int i = 1; i <= 8; i++) begin
            if (i == 8) check_eq("t1_empty_pre", 128'(empty), 128'(1));
            write_word(16'(i));
        end
        check_eq("t1_empty_post", 128'(empty), 128'(0));
        read_rec();
        check_eq("t1_dout", dout, 128'h0001_0002_0003_0004_0005_0006_0007_0008);
        check_eq("t1_empty_after", 128'(empty), 128'(1));

        // Partial record is invisible; read is rejected.
        do_reset();
        for (int i = 0; i < 7; i++) write_word(16'h0100 + 16'(i));
        check_eq("t2_empty", 128'(empty), 128'(1));
        read_rec();
        check_eq("t2_udf", 128'(underflow), 128'(1));
        check_eq("t2_dout", dout, 128'h0);
        check_eq("t2_empty_after", 128'(empty), 128'(1));
        step();
        check_eq("t2_udf_clear", 128'(underflow), 128'(0));
        do_reset();

        // Fill to full, overflow once, drain in order.
        for (int k = 0; k < 4096; k++) begin
            if (k == 4095) check_eq("t3_full_pre", 128'(full), 128'(0));
            write_word(16'(k));
        end
        check_eq("t3_full", 128'(full), 128'(1));
        check_eq("t3_not_empty", 128'(empty), 128'(0));
        write_word(16'hDEAD);
        check_eq("t3_ovf", 128'(overflow), 128'(1));
        check_eq("t3_full_hold", 128'(full), 128'(1));
        step();
        check_eq("t3_ovf_clear", 128'(overflow), 128'(0));
        rd_en = 1'b1;
        for (int r = 0; r < 512; r++) begin
            step();
            check_eq($sformatf("t3_drain_%0d", r), dout, rec_of(16'(8*r)));
            if (r == 0) check_eq("t3_full_drop", 128'(full), 128'(0));
        end
        rd_en = 1'b0;
        check_eq("t3_empty_end", 128'(empty), 128'(1));
        check_eq("t3_udf_none", 128'(underflow), 128'(0));
        // Rejected word must not have advanced the packing index.
        for (int i = 0; i < 8; i++) write_word(16'h1000 + 16'(i));
        read_rec();
        check_eq("t3_idx_kept", dout, rec_of(16'h1000));

        // Steady state: commit and pop together, across pointer wrap.
        for (int i = 0; i < 8; i++) write_word(16'h4000 + 16'(i));
        for (int n = 1; n <= 520; n++) begin
            base = 16'h4000 + 16'(8*n);
            for (int i = 0; i < 7; i++) write_word(base + 16'(i));
            din   = base + 16'd7;
            wr_en = 1'b1;
            rd_en = 1'b1;
            step();
            wr_en = 1'b0;
            rd_en = 1'b0;
            check_eq($sformatf("t4_dout_%0d", n), dout, rec_of(base - 16'd8));
            check_eq($sformatf("t4_empty_%0d", n), 128'(empty), 128'(0));
            check_eq($sformatf("t4_full_%0d", n), 128'(full), 128'(0));
        end
        read_rec();
        check_eq("t4_last", dout, rec_of(16'h4000 + 16'(8*520)));
        check_eq("t4_empty_end", 128'(empty), 128'(1));

        // Mid-record reset discards stored and partial records.
        for (int i = 0; i < 19; i++) write_word(16'h6000 + 16'(i));
        check_eq("t5_pre_empty", 128'(empty), 128'(0));
        #3;
        rst = 1'b1;
        #1;
        check_eq("t5_empty", 128'(empty), 128'(1));
        check_eq("t5_full", 128'(full), 128'(0));
        check_eq("t5_dout", dout, 128'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) write_word(16'hA001 + 16'(i));
        read_rec();
        check_eq("t5_top_slice", 128'(dout[127:112]), 128'(16'hA001));
        check_eq("t5_rec", dout, rec_of(16'hA001));

        // Segment field layout.
        seg = {48'h000000000005, 48'h000000000003, 32'h00000002};
        for (int j = 0; j < 8; j++) write_word(seg[127 - 16*j -: 16]);
        read_rec();
        check_eq("t6_on", 128'(dout[ON_MSB:ON_LSB]), 128'(48'h5));
        check_eq("t6_off", 128'(dout[OFF_MSB:OFF_LSB]), 128'(48'h3));
        check_eq("t6_rep", 128'(dout[REP_MSB:REP_LSB]), 128'(32'h2));
        check_eq("t6_pack", dout, seg_pack(48'h5, 48'h3, 32'h2));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
